mci_boot_seq_ctrl: RTL and testbench

Parametrised MCI boot sequencer that walks an ordered chain of `NUM_INIT` subsystem init handshakes (fuse controller, LCC, …), honours a SoC breakpoint, then releases Caliptra and `NUM_CORES` independently managed MCU-class cores. Each core has its own reset/firmware-update flow with a guaranteed minimum reset pulse. It sits in MCI between the SoC strap/register interface and the reset inputs of Caliptra and the cores.

---
 rtl/mci_pkg.sv | 28 ++
 rtl/caliptra_prim_flop_2sync.sv | 33 +++
 rtl/mci_core_rst_ctrl.sv | 86 ++++++++
 rtl/mci_boot_seq_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mci_boot_seq_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mci_pkg.sv
// -----------------------------------------------------------------------------
// mci_pkg
// Shared types for the MCI boot sequencer.
//   mci_boot_seq_state_e : top-level boot sequencer state (SEQ_IDLE is the
//                          all-zero reset encoding)
//   mci_core_rst_state_e : per-core reset / firmware-update state
// -----------------------------------------------------------------------------
package mci_pkg;

  typedef enum logic [3:0] {
    SEQ_IDLE          = 4'd0,
    SEQ_INIT          = 4'd1,
    SEQ_BRK_CHECK     = 4'd2,
    SEQ_BRKPOINT      = 4'd3,
    SEQ_CORE_BOOT     = 4'd4,
    SEQ_WAIT_CPTRA_GO = 4'd5,
    SEQ_CPTRA         = 4'd6,
    SEQ_RUN           = 4'd7,
    SEQ_UNKNOWN       = 4'd8
  } mci_boot_seq_state_e;

  typedef enum logic [1:0] {
    C_HELD = 2'd0,
    C_RUN  = 2'd1,
    C_RST  = 2'd2
  } mci_core_rst_state_e;

endpackage

// File: rtl/caliptra_prim_flop_2sync.sv
// -----------------------------------------------------------------------------
// caliptra_prim_flop_2sync
// Two-flop synchronizer for asynchronous level inputs.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset (flops load ResetValue)
//   d_i    : asynchronous input bus (bits are synchronized independently)
//   q_o    : synchronized output, 2 cycles of latency
// -----------------------------------------------------------------------------
module caliptra_prim_flop_2sync #(
  parameter int unsigned      Width      = 16,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse both stages.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      q_o    <= ResetValue;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/mci_core_rst_ctrl.sv
// -----------------------------------------------------------------------------
// mci_core_rst_ctrl
// Reset / firmware-update controller for one managed core.
//   clk, mci_rst_b   : clock and asynchronous active-low reset
//   core_release     : one-cycle release from the top sequencer (C_HELD->C_RUN)
//   run_en           : top sequencer is in SEQ_RUN; requests honoured only then
//   rst_req          : synchronous level reset request (registered once)
//   fw_lock          : firmware loaded; gates the exit from C_RST
//   core_rst_b       : core reset, active-low, registered
//   reset_once       : sticky, set once the core has been through C_RST
//   fw_boot_upd      : latched on a request taken before any reset
//   fw_hitless_upd   : latched on a request taken after a previous reset
// The reset pulse lasts 2^RST_CNT_W cycles minimum: the counter clears on
// entry, counts to all-ones and C_RST exits on the next edge with fw_lock.
// A request held high across the exit from C_RST is taken again as a new one.
// -----------------------------------------------------------------------------
module mci_core_rst_ctrl
  import mci_pkg::*;
#(
  parameter int unsigned RST_CNT_W = 4
) (
  input  logic clk,
  input  logic mci_rst_b,
  input  logic core_release,
  input  logic run_en,
  input  logic rst_req,
  input  logic fw_lock,
  output logic core_rst_b,
  output logic reset_once,
  output logic fw_boot_upd,
  output logic fw_hitless_upd
);

  mci_core_rst_state_e  state;
  logic                 req_q;
  logic [RST_CNT_W-1:0] cnt;
  logic                 elapsed;

  assign elapsed = (cnt == '1);

  always_ff @(posedge clk or negedge mci_rst_b) begin
    if (!mci_rst_b) begin
      state          <= C_HELD;
      req_q          <= 1'b0;
      cnt            <= '0;
      core_rst_b     <= 1'b0;
      reset_once     <= 1'b0;
      fw_boot_upd    <= 1'b0;
      fw_hitless_upd <= 1'b0;
    end else begin
      req_q <= rst_req;
      case (state)
        C_HELD, C_RUN: begin
          if (req_q && run_en) begin
            state          <= C_RST;
            core_rst_b     <= 1'b0;
            cnt            <= '0;
            // Old value of reset_once decides boot vs hitless update.
            fw_boot_upd    <= !reset_once;
            fw_hitless_upd <= reset_once;
          end else if ((state == C_HELD) && core_release) begin
            state      <= C_RUN;
            core_rst_b <= 1'b1;
          end
        end
        C_RST: begin
          // Further requests are deliberately ignored while in reset.
          reset_once <= 1'b1;
          core_rst_b <= 1'b0;
          if (!elapsed) begin
            cnt <= cnt + RST_CNT_W'(1);
          end
          if (elapsed && fw_lock) begin
            state      <= C_RUN;
            core_rst_b <= 1'b1;
          end
        end
        default: begin
          state      <= C_HELD;
          core_rst_b <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mci_boot_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mci_boot_seq_ctrl
// MCI boot sequencer: walks NUM_INIT ordered init handshakes, honours the SoC
// breakpoint, releases the cores (unless no_rom) and then Caliptra.
//   clk, mci_rst_b       : clock, asynchronous active-low reset
//   scan_mode            : forces cptra_rst_b / core_rst_b to follow mci_rst_b
//   init_o               : sticky per-stage init requests
//   init_done_i          : async per-stage done (2-flop synced)
//   brkpoint_i, no_rom_i : async straps (2-flop synced)
//   bootfsm_go_i         : sync level, leaves the breakpoint
//   cptra_go_i           : sync, releases Caliptra
//   cptra_rst_b          : Caliptra reset, active-low
//   core_rst_req_i       : per-core sync level reset request
//   core_fw_lock_i       : per-core firmware-loaded indication
//   core_rst_b           : per-core reset, active-low
//   core_reset_once_o    : per-core "has been reset" flag
//   fw_boot_upd_o        : per-core boot-update flag
//   fw_hitless_upd_o     : per-core hitless-update flag
//   boot_fsm_o           : current top-level state
//   init_err_o           : per-stage sticky timeout flags
// Optional feature: define MCI_BOOT_SEQ_INIT_TIMEOUT_EN to add a TIMEOUT_W
// stage timeout; otherwise stages wait forever and init_err_o is 0.
// -----------------------------------------------------------------------------
module mci_boot_seq_ctrl
  import mci_pkg::*;
#(
  parameter int unsigned NUM_INIT  = 2,
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned RST_CNT_W = 4,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 mci_rst_b,
  input  logic                 scan_mode,
  output logic [NUM_INIT-1:0]  init_o,
  input  logic [NUM_INIT-1:0]  init_done_i,
  input  logic                 brkpoint_i,
  input  logic                 bootfsm_go_i,
  input  logic                 no_rom_i,
  input  logic                 cptra_go_i,
  output logic                 cptra_rst_b,
  input  logic [NUM_CORES-1:0] core_rst_req_i,
  input  logic [NUM_CORES-1:0] core_fw_lock_i,
  output logic [NUM_CORES-1:0] core_rst_b,
  output logic [NUM_CORES-1:0] core_reset_once_o,
  output logic [NUM_CORES-1:0] fw_boot_upd_o,
  output logic [NUM_CORES-1:0] fw_hitless_upd_o,
  output mci_boot_seq_state_e  boot_fsm_o,
  output logic [NUM_INIT-1:0]  init_err_o
);

  localparam int unsigned     IDX_W    = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;
  localparam int unsigned     SYNC_W   = NUM_INIT + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INIT - 1);

  // ---------------------------------------------------------------------------
  // Synchronizers for the asynchronous inputs
  // ---------------------------------------------------------------------------
  logic [SYNC_W-1:0]   sync_q;
  logic [NUM_INIT-1:0] done_sync;
  logic                brk_sync;
  logic                no_rom_sync;

  caliptra_prim_flop_2sync #(
    .Width (SYNC_W)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (mci_rst_b),
    .d_i    ({no_rom_i, brkpoint_i, init_done_i}),
    .q_o    (sync_q)
  );

  assign {no_rom_sync, brk_sync, done_sync} = sync_q;

  // ---------------------------------------------------------------------------
  // Top-level sequencer state
  // ---------------------------------------------------------------------------
  mci_boot_seq_state_e state;
  logic [IDX_W-1:0]    idx;
  logic [NUM_INIT-1:0] init_q;
  logic                cptra_rst_q;
  logic                stage_timeout;

`ifdef MCI_BOOT_SEQ_INIT_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [NUM_INIT-1:0]  err_q;

  assign stage_timeout = (tmo_cnt == '1);

  // Counter restarts on every stage advance, whether by done or by timeout.
  always_ff @(posedge clk or negedge mci_rst_b) begin
    if (!mci_rst_b) begin
      tmo_cnt <= '0;
      err_q   <= '0;
    end else if (state == SEQ_INIT) begin
      if (done_sync[idx] || stage_timeout) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
      end
      if (stage_timeout && !done_sync[idx]) begin
        err_q[idx] <= 1'b1;
      end
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign init_err_o = err_q;
`else
  logic [TIMEOUT_W-1:0] timeout_unused;

  assign timeout_unused = '0;
  assign stage_timeout  = 1'b0;
  assign init_err_o     = '0;
`endif

  always_ff @(posedge clk or negedge mci_rst_b) begin
    if (!mci_rst_b) begin
      state       <= SEQ_IDLE;
      idx         <= '0;
      init_q      <= '0;
      cptra_rst_q <= 1'b0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          idx   <= '0;
          state <= SEQ_INIT;
        end
        SEQ_INIT: begin
          init_q[idx] <= 1'b1;
          if (done_sync[idx] || stage_timeout) begin
            if (idx == LAST_IDX) begin
              state <= SEQ_BRK_CHECK;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        SEQ_BRK_CHECK: begin
          if (brk_sync) begin
            state <= SEQ_BRKPOINT;
          end else if (no_rom_sync) begin
            state <= SEQ_WAIT_CPTRA_GO;
          end else begin
            state <= SEQ_CORE_BOOT;
          end
        end
        SEQ_BRKPOINT: begin
          if (bootfsm_go_i) begin
            state <= no_rom_sync ? SEQ_WAIT_CPTRA_GO : SEQ_CORE_BOOT;
          end
        end
        SEQ_CORE_BOOT:     state <= SEQ_WAIT_CPTRA_GO;
        SEQ_WAIT_CPTRA_GO: if (cptra_go_i) state <= SEQ_CPTRA;
        SEQ_CPTRA: begin
          cptra_rst_q <= 1'b1;
          state       <= SEQ_RUN;
        end
        SEQ_RUN:           state <= SEQ_RUN;
        SEQ_UNKNOWN:       state <= SEQ_UNKNOWN;
        default:           state <= SEQ_UNKNOWN;
      endcase
    end
  end

  // An X on the state register means a broken reset or an uninitialised path.
  a_state_known : assert property (@(posedge clk) disable iff (!mci_rst_b)
    !$isunknown(state));

  // ---------------------------------------------------------------------------
  // Per-core reset controllers
  // ---------------------------------------------------------------------------
  logic                 core_release;
  logic                 run_en;
  logic [NUM_CORES-1:0] core_rst_q;

  // Release is decoded from the registered state, so it lasts exactly the one
  // cycle spent in SEQ_CORE_BOOT.
  assign core_release = (state == SEQ_CORE_BOOT);
  assign run_en       = (state == SEQ_RUN);

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    mci_core_rst_ctrl #(
      .RST_CNT_W (RST_CNT_W)
    ) u_core (
      .clk            (clk),
      .mci_rst_b      (mci_rst_b),
      .core_release   (core_release),
      .run_en         (run_en),
      .rst_req        (core_rst_req_i[i]),
      .fw_lock        (core_fw_lock_i[i]),
      .core_rst_b     (core_rst_q[i]),
      .reset_once     (core_reset_once_o[i]),
      .fw_boot_upd    (fw_boot_upd_o[i]),
      .fw_hitless_upd (fw_hitless_upd_o[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Outputs; scan mode hands reset control straight to mci_rst_b
  // ---------------------------------------------------------------------------
  assign init_o      = init_q;
  assign boot_fsm_o  = state;
  assign cptra_rst_b = scan_mode ? mci_rst_b : cptra_rst_q;
  assign core_rst_b  = scan_mode ? {NUM_CORES{mci_rst_b}} : core_rst_q;

endmodule

// File: tb/tb_mci_boot_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mci_boot_seq_ctrl
// Directed bench for mci_boot_seq_ctrl (NUM_INIT=3, NUM_CORES=2, RST_CNT_W=4,
// TIMEOUT_W=4). Expected output values are queued as stimulus is applied and
// compared once the DUT has had the cycles to respond. Inputs change 1 time
// unit after a rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_mci_boot_seq_ctrl;
  import mci_pkg::*;

  localparam int unsigned NI = 3;
  localparam int unsigned NC = 2;

  logic                clk;
  logic                mci_rst_b;
  logic                scan_mode;
  logic [NI-1:0]       init_o;
  logic [NI-1:0]       init_done_i;
  logic                brkpoint_i;
  logic                bootfsm_go_i;
  logic                no_rom_i;
  logic                cptra_go_i;
  logic                cptra_rst_b;
  logic [NC-1:0]       core_rst_req_i;
  logic [NC-1:0]       core_fw_lock_i;
  logic [NC-1:0]       core_rst_b;
  logic [NC-1:0]       core_reset_once_o;
  logic [NC-1:0]       fw_boot_upd_o;
  logic [NC-1:0]       fw_hitless_upd_o;
  mci_boot_seq_state_e boot_fsm_o;
  logic [NI-1:0]       init_err_o;

  mci_boot_seq_ctrl #(
    .NUM_INIT  (NI),
    .NUM_CORES (NC),
    .RST_CNT_W (4),
    .TIMEOUT_W (4)
  ) dut (
    .clk               (clk),
    .mci_rst_b         (mci_rst_b),
    .scan_mode         (scan_mode),
    .init_o            (init_o),
    .init_done_i       (init_done_i),
    .brkpoint_i        (brkpoint_i),
    .bootfsm_go_i      (bootfsm_go_i),
    .no_rom_i          (no_rom_i),
    .cptra_go_i        (cptra_go_i),
    .cptra_rst_b       (cptra_rst_b),
    .core_rst_req_i    (core_rst_req_i),
    .core_fw_lock_i    (core_fw_lock_i),
    .core_rst_b        (core_rst_b),
    .core_reset_once_o (core_reset_once_o),
    .fw_boot_upd_o     (fw_boot_upd_o),
    .fw_hitless_upd_o  (fw_hitless_upd_o),
    .boot_fsm_o        (boot_fsm_o),
    .init_err_o        (init_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef enum {O_INIT, O_STATE, O_CPTRA, O_CORE, O_BOOT, O_HITLESS, O_ONCE, O_ERR} obs_e;

  typedef struct {
    string       tag;
    obs_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] observe(input obs_e s);
    case (s)
      O_INIT:    return 32'(init_o);
      O_STATE:   return 32'(boot_fsm_o);
      O_CPTRA:   return 32'(cptra_rst_b);
      O_CORE:    return 32'(core_rst_b);
      O_BOOT:    return 32'(fw_boot_upd_o);
      O_HITLESS: return 32'(fw_hitless_upd_o);
      O_ONCE:    return 32'(core_reset_once_o);
      O_ERR:     return 32'(init_err_o);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input obs_e sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mci_rst_b = 1'b0;
    step(2);
    mci_rst_b = 1'b1;
  endtask

  // Pulse a core request for exactly one cycle; returns one edge later.
  task automatic pulse_req(input logic [NC-1:0] req);
    core_rst_req_i = req;
    step(1);
    core_rst_req_i = '0;
  endtask

  task automatic expect_all_zero(input string tag);
    expect_out({tag, "_init"},    O_INIT,    0);
    expect_out({tag, "_state"},   O_STATE,   32'(SEQ_IDLE));
    expect_out({tag, "_cptra"},   O_CPTRA,   0);
    expect_out({tag, "_core"},    O_CORE,    0);
    expect_out({tag, "_boot"},    O_BOOT,    0);
    expect_out({tag, "_hitless"}, O_HITLESS, 0);
    expect_out({tag, "_once"},    O_ONCE,    0);
    expect_out({tag, "_err"},     O_ERR,     0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    mci_rst_b      = 1'b0;
    scan_mode      = 1'b0;
    init_done_i    = '0;
    brkpoint_i     = 1'b0;
    bootfsm_go_i   = 1'b0;
    no_rom_i       = 1'b0;
    cptra_go_i     = 1'b0;
    core_rst_req_i = '0;
    core_fw_lock_i = '1;

    // ---- A: in-order init chain, no breakpoint, ROM boot --------------------
    step(1);
    expect_all_zero("rst");
    drain();

    do_reset();
    step(2);
    expect_out("a_init_001", O_INIT, 3'b001);
    expect_out("a_state_init", O_STATE, 32'(SEQ_INIT));
    drain();

    init_done_i = 3'b001;
    step(4);
    expect_out("a_init_011", O_INIT, 3'b011);
    drain();

    init_done_i = 3'b011;
    step(4);
    expect_out("a_init_111", O_INIT, 3'b111);
    drain();

    init_done_i = 3'b111;
    step(3);
    expect_out("a_state_brkchk", O_STATE, 32'(SEQ_BRK_CHECK));
    drain();
    step(1);
    expect_out("a_state_coreboot", O_STATE, 32'(SEQ_CORE_BOOT));
    expect_out("a_core_held", O_CORE, 2'b00);
    drain();
    step(1);
    expect_out("a_core_released", O_CORE, 2'b11);
    expect_out("a_state_wait", O_STATE, 32'(SEQ_WAIT_CPTRA_GO));
    expect_out("a_err_none", O_ERR, 0);
    drain();

    cptra_go_i = 1'b1;
    step(1);
    cptra_go_i = 1'b0;
    expect_out("a_cptra_still_low", O_CPTRA, 0);
    drain();
    step(1);
    expect_out("a_cptra_high", O_CPTRA, 1);
    expect_out("a_state_run", O_STATE, 32'(SEQ_RUN));
    drain();

    // ---- B: done already high, breakpoint held 100 cycles -------------------
    brkpoint_i = 1'b1;
    do_reset();
    step(4);
    expect_out("b_init_fast_011", O_INIT, 3'b011);
    expect_out("b_state_init", O_STATE, 32'(SEQ_INIT));
    drain();
    step(1);
    expect_out("b_init_fast_111", O_INIT, 3'b111);
    expect_out("b_state_brkchk", O_STATE, 32'(SEQ_BRK_CHECK));
    drain();
    step(1);
    expect_out("b_state_brkpoint", O_STATE, 32'(SEQ_BRKPOINT));
    drain();
    step(100);
    expect_out("b_brkpoint_held", O_STATE, 32'(SEQ_BRKPOINT));
    expect_out("b_core_held", O_CORE, 2'b00);
    drain();

    bootfsm_go_i = 1'b1;
    step(1);
    expect_out("b_state_coreboot", O_STATE, 32'(SEQ_CORE_BOOT));
    expect_out("b_core_low_1cyc", O_CORE, 2'b00);
    drain();
    step(1);
    expect_out("b_core_high_2cyc", O_CORE, 2'b11);
    drain();
    bootfsm_go_i = 1'b0;
    brkpoint_i   = 1'b0;

    // ---- C: no_rom, cores held until first request --------------------------
    no_rom_i = 1'b1;
    do_reset();
    step(6);
    expect_out("c_state_wait", O_STATE, 32'(SEQ_WAIT_CPTRA_GO));
    drain();
    cptra_go_i = 1'b1;
    step(2);
    cptra_go_i = 1'b0;
    step(3);
    expect_out("c_state_run", O_STATE, 32'(SEQ_RUN));
    expect_out("c_cptra_high", O_CPTRA, 1);
    expect_out("c_core_held_in_run", O_CORE, 2'b00);
    drain();

    // Core 1 request: boot update, 16-cycle reset pulse
    pulse_req(2'b10);
    step(1);
    expect_out("c1_boot_upd", O_BOOT, 2'b10);
    expect_out("c1_hitless", O_HITLESS, 2'b00);
    expect_out("c1_core_low", O_CORE, 2'b00);
    drain();
    step(15);
    expect_out("c1_core_low_at_15", O_CORE, 2'b00);
    expect_out("c1_once", O_ONCE, 2'b10);
    drain();
    step(1);
    expect_out("c1_core_high_at_16", O_CORE, 2'b10);
    drain();

    // Core 0 first request: boot update
    pulse_req(2'b01);
    step(1);
    expect_out("c0a_boot_upd", O_BOOT, 2'b11);
    expect_out("c0a_hitless", O_HITLESS, 2'b00);
    drain();
    step(16);
    expect_out("c0a_core_high", O_CORE, 2'b11);
    drain();

    // Core 0 second request: hitless, release gated by late fw_lock
    core_fw_lock_i = 2'b10;
    pulse_req(2'b01);
    step(1);
    expect_out("c0b_core_low", O_CORE, 2'b10);
    expect_out("c0b_boot_upd", O_BOOT, 2'b10);
    expect_out("c0b_hitless", O_HITLESS, 2'b01);
    expect_out("c0b_once", O_ONCE, 2'b11);
    drain();
    step(38);
    expect_out("c0b_lock_gates", O_CORE, 2'b10);
    drain();
    core_fw_lock_i = 2'b11;
    step(1);
    expect_out("c0b_core_high", O_CORE, 2'b11);
    drain();

    // Simultaneous requests, plus a repeat while in C_RST
    pulse_req(2'b11);
    expect_out("sim_core_high_1cyc", O_CORE, 2'b11);
    drain();
    step(1);
    expect_out("sim_core_low", O_CORE, 2'b00);
    expect_out("sim_hitless", O_HITLESS, 2'b11);
    expect_out("sim_boot_upd", O_BOOT, 2'b00);
    drain();
    step(3);
    pulse_req(2'b11);
    step(11);
    expect_out("sim_core_low_at_15", O_CORE, 2'b00);
    drain();
    step(1);
    expect_out("sim_core_high_at_16", O_CORE, 2'b11);
    drain();
    step(2);
    expect_out("sim_repeat_ignored", O_CORE, 2'b11);
    drain();

    // ---- D: async reset mid-C_RST, then scan bypass -------------------------
    pulse_req(2'b01);
    step(3);
    #2;
    mci_rst_b = 1'b0;
    #1;
    expect_all_zero("d_async");
    drain();

    scan_mode = 1'b1;
    #1;
    expect_out("d_scan_core_rst", O_CORE, 2'b00);
    expect_out("d_scan_cptra_rst", O_CPTRA, 0);
    drain();
    step(1);
    mci_rst_b = 1'b1;
    #1;
    expect_out("d_scan_core_follow", O_CORE, 2'b11);
    expect_out("d_scan_cptra_follow", O_CPTRA, 1);
    drain();
    scan_mode = 1'b0;
    #1;
    expect_out("d_noscan_core", O_CORE, 2'b00);
    expect_out("d_noscan_cptra", O_CPTRA, 0);
    drain();

`ifdef MCI_BOOT_SEQ_INIT_TIMEOUT_EN
    // ---- E: stage timeout with no done ---------------------------------------
    no_rom_i    = 1'b0;
    init_done_i = '0;
    do_reset();
    step(16);
    expect_out("e_err_not_yet", O_ERR, 3'b000);
    expect_out("e_init_001", O_INIT, 3'b001);
    drain();
    step(1);
    expect_out("e_err_stage0", O_ERR, 3'b001);
    drain();
    step(1);
    expect_out("e_chain_advanced", O_INIT, 3'b011);
    expect_out("e_err_sticky", O_ERR, 3'b001);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
